// File: rtl/lsu_avm_width_adapter.sv
// Avalon-MM width adapter: wide LSU master <-> narrow global-memory port.
// Writes are sliced into RATIO beats (slice 0 first), reads pass through in IDLE
// and are reassembled from RATIO beats, per-beat write acks fold into word acks.
// Optional: define LSU_WIDE_RDATA_BYPASS_EN for zero-latency read-data return.
module lsu_avm_width_adapter #(
  parameter int unsigned AWIDTH           = 32,
  parameter int unsigned WIDE_BYTES       = 64,
  parameter int unsigned MWIDTH_BYTES     = 16,
  parameter int unsigned BURSTCOUNT_WIDTH = 6,
  parameter int unsigned PENDING_WIDTH    = 10,
  localparam int unsigned RATIO           = WIDE_BYTES / MWIDTH_BYTES,
  localparam int unsigned IW              = $clog2(RATIO),
  localparam int unsigned SBW             = BURSTCOUNT_WIDTH - IW
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [AWIDTH-1:0]             s_address,
  input  logic                          s_read,
  input  logic                          s_write,
  input  logic [8*WIDE_BYTES-1:0]       s_writedata,
  input  logic [WIDE_BYTES-1:0]         s_byteenable,
  input  logic [SBW-1:0]                s_burstcount,
  output logic                          s_waitrequest,
  output logic [8*WIDE_BYTES-1:0]       s_readdata,
  output logic                          s_readdatavalid,
  output logic                          s_writeack,
  output logic [AWIDTH-1:0]             m_address,
  output logic                          m_read,
  output logic                          m_write,
  output logic [8*MWIDTH_BYTES-1:0]     m_writedata,
  output logic [MWIDTH_BYTES-1:0]       m_byteenable,
  output logic [BURSTCOUNT_WIDTH-1:0]   m_burstcount,
  input  logic                          m_waitrequest,
  input  logic [8*MWIDTH_BYTES-1:0]     m_readdata,
  input  logic                          m_readdatavalid,
  input  logic                          m_writeack,
  output logic                          o_active
);

  localparam int unsigned WB  = 8 * WIDE_BYTES;
  localparam int unsigned MB  = 8 * MWIDTH_BYTES;
  localparam int unsigned PW  = PENDING_WIDTH;
  localparam int unsigned PW1 = PENDING_WIDTH + 1;
  localparam logic [IW-1:0] LAST = IW'(RATIO - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [AWIDTH-1:0]          addr_q, addr_d;
  logic [WB-1:0]              wdata_q, wdata_d;
  logic [WIDE_BYTES-1:0]      be_q, be_d;
  logic [SBW-1:0]             burst_q, burst_d;
  logic [SBW-1:0]             rem_q, rem_d;
  logic                       wr_cap;

  logic [WB-1:0]              sr_q, sr_next;
  logic [IW-1:0]              rd_idx_q, ack_idx_q;
  logic                       rd_last;
  logic [PW-1:0]              pend_rd_q, pend_rd_d, pend_ack_q, pend_ack_d;
  logic                       active_q, active_d;

  logic [RATIO-1:0][MB-1:0]           wslices;
  logic [RATIO-1:0][MWIDTH_BYTES-1:0] bslices;

  // Saturating counter update: add first (clamp at all-ones), then subtract without underflow.
  function automatic logic [PW-1:0] sat_update(input logic [PW-1:0] cur,
                                               input logic [PW-1:0] add,
                                               input logic sub);
    logic [PW1-1:0] sum;
    sum = {1'b0, cur} + {1'b0, add};
    if (sum[PW]) sum = {1'b0, {PW{1'b1}}};
    if (sub && (sum != '0)) sum = sum - PW1'(1);
    return sum[PW-1:0];
  endfunction

  // Write FSM next-state and command-side muxing (read pass-through in IDLE).
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    burst_d       = burst_q;
    rem_d         = rem_q;
    wr_cap        = 1'b0;
    s_waitrequest = 1'b1;
    m_read        = 1'b0;
    m_address     = addr_q;
    m_burstcount  = {burst_q, {IW{1'b0}}};
    case (state_q)
      IDLE: begin
        m_address    = s_address;
        m_burstcount = {s_burstcount, {IW{1'b0}}};
        if (s_write) begin
          s_waitrequest = 1'b0;
          wr_cap        = 1'b1;
          idx_d         = '0;
          state_d       = SEND;
        end else begin
          m_read        = s_read;
          s_waitrequest = m_waitrequest;
        end
      end
      SEND: begin
        if (!m_waitrequest) begin
          if (idx_q == LAST) begin
            s_waitrequest = 1'b0;
            idx_d         = '0;
            if (s_write) wr_cap = 1'b1;
            else         state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Follow-on words of a burst keep the captured address and burstcount.
    if (wr_cap) begin
      wdata_d = s_writedata;
      be_d    = s_byteenable;
      if (rem_q == '0) begin
        addr_d  = s_address;
        burst_d = s_burstcount;
        rem_d   = s_burstcount - SBW'(1);
      end else begin
        rem_d   = rem_q - SBW'(1);
      end
    end
  end

  assign wslices      = wdata_q;
  assign bslices      = be_q;
  assign m_write      = (state_q == SEND);
  assign m_writedata  = wslices[idx_q];
  assign m_byteenable = bslices[idx_q];

  // Newest beat enters at the top, so after RATIO beats slice 0 holds the first beat.
  assign sr_next    = {m_readdata, sr_q[WB-1:MB]};
  assign rd_last    = m_readdatavalid && (rd_idx_q == LAST);
  assign s_writeack = m_writeack && (ack_idx_q == LAST);

`ifdef LSU_WIDE_RDATA_BYPASS_EN
  assign s_readdata      = sr_next;
  assign s_readdatavalid = rd_last;
`else
  logic rdv_q;

  // Registered read-word valid, one cycle after the final beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rdv_q <= 1'b0;
    else         rdv_q <= rd_last;
  end

  assign s_readdata      = sr_q;
  assign s_readdatavalid = rdv_q;
`endif

  // In-flight bookkeeping and activity flag.
  always_comb begin
    pend_rd_d  = sat_update(pend_rd_q, (m_read && !m_waitrequest) ? PW'(s_burstcount) : '0,
                            s_readdatavalid);
    pend_ack_d = sat_update(pend_ack_q, PW'(wr_cap), s_writeack);
    active_d   = (state_d != IDLE) || (pend_rd_d != '0) || (pend_ack_d != '0);
  end

  assign o_active = active_q;

  // State, capture, assembly and counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      burst_q    <= '0;
      rem_q      <= '0;
      sr_q       <= '0;
      rd_idx_q   <= '0;
      ack_idx_q  <= '0;
      pend_rd_q  <= '0;
      pend_ack_q <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      burst_q    <= burst_d;
      rem_q      <= rem_d;
      pend_rd_q  <= pend_rd_d;
      pend_ack_q <= pend_ack_d;
      active_q   <= active_d;
      if (m_readdatavalid) begin
        sr_q     <= sr_next;
        rd_idx_q <= rd_idx_q + IW'(1);
      end
      if (m_writeack) ack_idx_q <= ack_idx_q + IW'(1);
    end
  end

endmodule
